// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst read/write initiator for a 16x8 single-port synchronous memory
//
// Accepts a burst command (start address, beats-1) over a valid/ready channel,
// streams write beats in and read beats out with valid/ready handshakes, and
// drives the memory address/data/write-enable pins.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write, cmd_addr, cmd_len    burst direction, start word, beats minus 1
//   wr_data/wr_valid/wr_ready       write beat stream
//   rd_data/rd_valid/rd_ready       read beat stream
//   busy, done                      burst in progress, one-cycle completion pulse
//   Address, WriteToMemory,
//   ReadOrWrite, ReadFromMemory     memory pins (ReadOrWrite=1 writes)
module mem_burst_ctrl #(
  parameter int DATA_W     = 8,
  parameter int MEM_ADDR_W = 5,
  parameter int DEPTH      = 16,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [PTR_W-1:0]      cmd_addr,
  input  logic [PTR_W-1:0]      cmd_len,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic [MEM_ADDR_W-1:0] Address,
  output logic [DATA_W-1:0]     WriteToMemory,
  output logic                  ReadOrWrite,
  input  logic [DATA_W-1:0]     ReadFromMemory
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_WAIT,
    S_RD_CAPT,
    S_RD_HOLD,
    S_DONE
  } state_t;

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [MEM_ADDR_W-PTR_W-1:0] ADDR_PAD = '0;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        cnt_q, cnt_d;
  logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    rw_q, rw_d;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [PTR_W-1:0]        ptr_nx;

  // Pointer wraps modulo DEPTH, so the upper address bits stay zero.
  assign ptr_nx = ptr_q + PTR_ONE;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = 1'b0;     // write enable is only asserted for an accepted write beat
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ptr_d = cmd_addr;
          cnt_d = cmd_len;
          if (cmd_write) begin
            state_d = S_WRITE;
          end else begin
            addr_d  = {ADDR_PAD, cmd_addr};
            state_d = S_RD_WAIT;
          end
        end
      end
      S_WRITE: begin
        if (wr_valid) begin
          addr_d  = {ADDR_PAD, ptr_q};
          wdata_d = wr_data;
          rw_d    = 1'b1;
          ptr_d   = ptr_nx;
          cnt_d   = cnt_q - PTR_ONE;
          if (cnt_q == '0) state_d = S_DONE;
        end
      end
      S_RD_WAIT: state_d = S_RD_CAPT;   // memory samples Address at the end of this cycle
      S_RD_CAPT: begin
        rd_data_d  = ReadFromMemory;
        rd_valid_d = 1'b1;
        state_d    = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_nx;
            cnt_d   = cnt_q - PTR_ONE;
            addr_d  = {ADDR_PAD, ptr_nx};
            state_d = S_RD_WAIT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;         // last write beat commits at the end of this cycle
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign wr_ready      = (state_q == S_WRITE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign Address       = addr_q;
  assign WriteToMemory = wdata_q;
  assign ReadOrWrite   = rw_q;
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - directed self-checking bench for mem_burst_ctrl with a 16x8 memory model
module tb_mem_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, rd_ready;
  logic       busy, done;
  logic [4:0] Address;
  logic [7:0] WriteToMemory;
  logic       ReadOrWrite;
  logic [7:0] ReadFromMemory;

  logic [7:0] mem [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done),
    .Address(Address), .WriteToMemory(WriteToMemory), .ReadOrWrite(ReadOrWrite),
    .ReadFromMemory(ReadFromMemory)
  );

  // Single-port synchronous memory: write when ReadOrWrite=1, otherwise read.
  always @(posedge clk) begin
    if (ReadOrWrite) mem[Address] <= WriteToMemory;
    else             ReadFromMemory <= mem[Address];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_cmd(input logic w, input logic [3:0] a, input logic [3:0] len);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d [4],
                          input int gap_at, input int gap_len);
    logic [3:0] ai;
    issue_cmd(1'b1, a, 4'd3);
    chk("wr_ready", wr_ready, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          wr_valid = 1'b0;
          @(negedge clk);
          chk("wr_gap_rw", ReadOrWrite, 0);
          chk("wr_gap_ready", wr_ready, 1);
        end
      end
      wr_valid = 1'b1;
      wr_data  = d[i];
      @(negedge clk);
      ai = a + 4'(i);
      chk("wr_addr", Address, {1'b0, ai});
      chk("wr_rw", ReadOrWrite, 1);
      chk("wr_data", WriteToMemory, d[i]);
      chk("wr_done", done, (i == 3));
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_end_done", done, 0);
    chk("wr_end_cmd_ready", cmd_ready, 1);
    chk("wr_end_rw", ReadOrWrite, 0);
    for (int i = 0; i < 4; i++) begin
      ai = a + 4'(i);
      chk("wr_mem", mem[{1'b0, ai}], d[i]);
    end
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] d [4],
                         input int hold_at, input int hold_len);
    logic [3:0] ai;
    rd_ready = 1'b1;
    issue_cmd(1'b0, a, 4'd3);
    for (int i = 0; i < 4; i++) begin
      ai = a + 4'(i);
      chk("rd_addr", Address, {1'b0, ai});
      chk("rd_rw", ReadOrWrite, 0);
      chk("rd_valid_wait", rd_valid, 0);
      @(negedge clk);
      chk("rd_valid_capt", rd_valid, 0);
      @(negedge clk);
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, d[i]);
      if (i == hold_at) begin
        rd_ready = 1'b0;
        for (int h = 0; h < hold_len; h++) begin
          @(negedge clk);
          chk("hold_valid", rd_valid, 1);
          chk("hold_data", rd_data, d[i]);
          chk("hold_addr", Address, {1'b0, ai});
        end
        rd_ready = 1'b1;
      end
      @(negedge clk);
      chk("rd_valid_drop", rd_valid, 0);
      chk("rd_done", done, (i == 3));
    end
    chk("rd_done_busy", busy, 1);
    chk("rd_done_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("rd_end_done", done, 0);
    chk("rd_end_cmd_ready", cmd_ready, 1);
    chk("rd_end_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] vec [4];
    for (int i = 0; i < 32; i++) mem[i] = 8'h10 + 8'(i);
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", Address, 0);
    chk("rst_rw", ReadOrWrite, 0);
    chk("rst_rd_valid", rd_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back write and read-back at 3..6
    vec = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_write(4'd3, vec, -1, 0);
    do_read(4'd3, vec, -1, 0);

    // Wrap across the top of the address space
    vec = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(4'd14, vec, -1, 0);
    do_read(4'd14, vec, -1, 0);

    // Write with a 2-cycle valid gap, read back with 5 cycles of backpressure
    vec = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
    do_write(4'd10, vec, 2, 2);
    chk("gap_neighbor_lo", mem[9], 8'h19);
    chk("gap_neighbor_hi", mem[14], 8'h11);
    do_read(4'd10, vec, 1, 5);

    // Asynchronous reset while a read beat is being held
    rd_ready = 1'b1;
    issue_cmd(1'b0, 4'd3, 4'd3);
    @(negedge clk);
    rd_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_rd_valid", rd_valid, 1);
    chk("pre_rst_rd_data", rd_data, 8'hA0);
    rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_addr", Address, 0);
    chk("arst_wdata", WriteToMemory, 0);
    chk("arst_rw", ReadOrWrite, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_busy", busy, 0);
    #1;
    rst_n = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // Reset mid-write: beat 0 commits, beat 1 is aborted
    issue_cmd(1'b1, 4'd8, 4'd3);
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    @(negedge clk);
    chk("mw_addr0", Address, 8);
    chk("mw_rw0", ReadOrWrite, 1);
    wr_data = 8'h66;
    @(negedge clk);
    chk("mw_addr1", Address, 9);
    chk("mw_rw1", ReadOrWrite, 1);
    rst_n = 1'b0;
    #1;
    chk("mw_arst_rw", ReadOrWrite, 0);
    chk("mw_arst_busy", busy, 0);
    wr_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mw_word8", mem[8], 8'h55);
    chk("mw_word9", mem[9], 8'h19);
    chk("mw_word10", mem[10], 8'h5A);
    chk("mw_idle", cmd_ready, 1);
    chk("mw_wr_ready", wr_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
